// File: rtl/tdes_pkg.sv
// Shared TDES sequencer definitions: FSM state codes, key-select codes and the
// key-schedule rotate tables used by both this controller and the C/D datapath.
package tdes_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRound,
    StWait,
    StPass,
    StDone
  } state_e;

  localparam logic [1:0] KEY_K1 = 2'd0;
  localparam logic [1:0] KEY_K2 = 2'd1;
  localparam logic [1:0] KEY_K3 = 2'd2;

  // Bit r set: encrypt-direction round r rotates by 2, else by 1.
  localparam logic [15:0] ENC_SHIFT2_MASK = 16'h7EFC;

  // Decrypt-direction rotate amount for round r lives in bits [2r+1:2r].
  // Round 0 rotates by 0 because PC1 already yields the K16 alignment.
  localparam logic [31:0] DEC_SHIFT_TABLE = 32'h6AA9_AAA4;

  // Key used for a pass: EDE encrypt walks K1,K2,K3; decrypt walks K3,K2,K1.
  function automatic logic [1:0] pass_key(input logic dec, input logic [1:0] pass,
                                          input int unsigned num_passes);
    if (num_passes == 1) return KEY_K1;
    return dec ? (KEY_K3 - pass) : pass;
  endfunction

endpackage

// File: rtl/tdes_shift_sched.sv
// Combinational key-schedule rotate amount for a given round and direction.
module tdes_shift_sched
  import tdes_pkg::*;
(
  input  logic [3:0] round_i,
  input  logic       dir_i,
  output logic [1:0] shift_o
);

  // Table lookup: right-rotate table for D passes, 1/2 mask for E passes.
  always_comb begin
    if (dir_i) begin
      shift_o = DEC_SHIFT_TABLE[{round_i, 1'b0} +: 2];
    end else begin
      shift_o = ENC_SHIFT2_MASK[round_i] ? 2'd2 : 2'd1;
    end
  end

endmodule

// File: rtl/tdes_round_ctrl.sv
// Round sequencer for the iterative DES/TDES core. Drives load, round-enable,
// key-select and key-schedule controls over NUM_PASSES x 16 rounds, then holds
// a result-valid handshake. Optional macro TDES_CTRL_ABORT_EN adds abort_i.
module tdes_round_ctrl
  import tdes_pkg::*;
#(
  parameter int unsigned NUM_PASSES = 3,
  parameter int unsigned SBOX_LAT   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       mode_dec_i,
  output logic       in_ready_o,
  output logic       busy_o,
  output logic       load_o,
  output logic       ks_load_o,
  output logic [1:0] key_sel_o,
  output logic       ks_dir_o,
  output logic [1:0] ks_shift_o,
  output logic       round_en_o,
  output logic       no_swap_o,
  output logic [3:0] round_o,
  output logic [1:0] pass_o,
  output logic       out_valid_o,
`ifdef TDES_CTRL_ABORT_EN
  input  logic       abort_i,
`endif
  input  logic       out_ready_i
);

  if (!(NUM_PASSES == 1 || NUM_PASSES == 3)) begin : g_bad_num_passes
    $error("tdes_round_ctrl: NUM_PASSES must be 1 or 3");
  end
  if (SBOX_LAT > 1) begin : g_bad_sbox_lat
    $error("tdes_round_ctrl: SBOX_LAT must be 0 or 1");
  end

  localparam logic [1:0] LastPass = 2'(NUM_PASSES - 1);

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [1:0] pass_q, pass_d;
  logic       dec_q, dec_d;
  logic       commit;
  logic       abort;
  logic       dir;
  logic [1:0] sched_shift;

`ifdef TDES_CTRL_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  // Pass direction: the middle pass of EDE runs opposite to the block mode.
  assign dir = dec_q ^ (pass_q == 2'd1);

  tdes_shift_sched u_shift_sched (
    .round_i (round_q),
    .dir_i   (dir),
    .shift_o (sched_shift)
  );

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    pass_d  = pass_q;
    dec_d   = dec_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StLoad;
          dec_d   = mode_dec_i;
          round_d = 4'd0;
          pass_d  = 2'd0;
        end
      end
      StLoad:  state_d = StRound;
      StRound: begin
        if (SBOX_LAT != 0) state_d = StWait;
        else               commit  = 1'b1;
      end
      StWait:  commit  = 1'b1;
      StPass:  state_d = StRound;
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
          round_d = 4'd0;
          pass_d  = 2'd0;
          dec_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    // A round finishes: advance round, and pass/terminate after round 15.
    if (commit) begin
      round_d = round_q + 4'd1;
      state_d = StRound;
      if (round_q == 4'd15) begin
        if (pass_q == LastPass) begin
          state_d = StDone;
        end else begin
          state_d = StPass;
          pass_d  = pass_q + 2'd1;
        end
      end
    end
    if (abort && state_q != StIdle) begin
      state_d = StIdle;
      round_d = 4'd0;
      pass_d  = 2'd0;
      dec_d   = 1'b0;
    end
  end

  // Control outputs decoded from the current state and counters.
  always_comb begin
    in_ready_o  = (state_q == StIdle);
    busy_o      = (state_q != StIdle);
    load_o      = (state_q == StLoad);
    ks_load_o   = (state_q == StLoad) || (state_q == StPass);
    key_sel_o   = busy_o ? pass_key(dec_q, pass_q, NUM_PASSES) : KEY_K1;
    ks_dir_o    = busy_o & dir;
    ks_shift_o  = ((state_q == StRound) || (state_q == StWait)) ? sched_shift : 2'd0;
    round_en_o  = commit;
    no_swap_o   = commit && (round_q == 4'd15);
    round_o     = round_q;
    pass_o      = pass_q;
    out_valid_o = (state_q == StDone);
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      round_q <= 4'd0;
      pass_q  <= 2'd0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      pass_q  <= pass_d;
      dec_q   <= dec_d;
    end
  end

endmodule

// File: tb/tb_tdes_round_ctrl.sv
// Bench for tdes_round_ctrl: a default TDES instance and a single-DES,
// SBOX_LAT=1 instance, checked cycle by cycle against a trace model.
module tb_tdes_round_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start_s[2], mode_s[2], ordy_s[2], abort_s[2];
  logic       in_ready[2], busy[2], load[2], ks_load[2], ks_dir[2];
  logic       round_en[2], no_swap[2], out_valid[2];
  logic [1:0] key_sel[2], ks_shift[2], pass_v[2];
  logic [3:0] round_v[2];
  logic [17:0] obs[2];

  for (genvar g = 0; g < 2; g++) begin : g_obs
    assign obs[g] = {in_ready[g], busy[g], load[g], ks_load[g], key_sel[g], ks_dir[g],
                     ks_shift[g], round_en[g], no_swap[g], round_v[g], pass_v[g],
                     out_valid[g]};
  end

  tdes_round_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start_s[0]), .mode_dec_i(mode_s[0]),
    .in_ready_o(in_ready[0]), .busy_o(busy[0]), .load_o(load[0]), .ks_load_o(ks_load[0]),
    .key_sel_o(key_sel[0]), .ks_dir_o(ks_dir[0]), .ks_shift_o(ks_shift[0]),
    .round_en_o(round_en[0]), .no_swap_o(no_swap[0]), .round_o(round_v[0]),
    .pass_o(pass_v[0]), .out_valid_o(out_valid[0]),
`ifdef TDES_CTRL_ABORT_EN
    .abort_i(abort_s[0]),
`endif
    .out_ready_i(ordy_s[0])
  );

  tdes_round_ctrl #(.NUM_PASSES(1), .SBOX_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start_s[1]), .mode_dec_i(mode_s[1]),
    .in_ready_o(in_ready[1]), .busy_o(busy[1]), .load_o(load[1]), .ks_load_o(ks_load[1]),
    .key_sel_o(key_sel[1]), .ks_dir_o(ks_dir[1]), .ks_shift_o(ks_shift[1]),
    .round_en_o(round_en[1]), .no_swap_o(no_swap[1]), .round_o(round_v[1]),
    .pass_o(pass_v[1]), .out_valid_o(out_valid[1]),
`ifdef TDES_CTRL_ABORT_EN
    .abort_i(abort_s[1]),
`endif
    .out_ready_i(ordy_s[1])
  );

  // Field masks inside the 18-bit observation word.
  localparam logic [17:0] ALL    = 18'h3FFFF;
  localparam logic [17:0] M_DIR  = 18'h00800;
  localparam logic [17:0] M_SH   = 18'h00600;
  localparam logic [17:0] M_KEY  = 18'h03000;
  localparam logic [17:0] M_PASS = 18'h00006;
  localparam logic [17:0] M_RND  = 18'h00078;
  localparam logic [17:0] IDLE_REC = 18'h20000;
  localparam logic [17:0] DONE_REC = 18'h10001;
  localparam logic [17:0] DONE_MSK = ALL & ~(M_KEY | M_DIR | M_SH | M_RND | M_PASS);

  int enc_tab[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  int dec_tab[16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  int n_checks = 0;
  int n_fail   = 0;
  logic [17:0] exp_q[$];
  logic [17:0] msk_q[$];
  logic [1:0]  obs_key[3];
  logic        obs_dir[3];

  typedef struct {
    int         d;
    logic       mode;
    int         delay;
    logic       noisy;
    int         lat;
    logic [1:0] k0, k1, k2;
    logic       dr0, dr1, dr2;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp,
                       input logic [17:0] mask);
    n_checks++;
    if (((act ^ exp) & mask) !== 18'd0) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (mask %h)", name, act, exp, mask);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [17:0] rec(input logic busy_b, input logic load_b,
                                      input logic ksl_b, input int key, input logic dir_b,
                                      input int sh, input logic ren_b, input logic nsw_b,
                                      input int rnd, input int pas, input logic val_b);
    return {1'b0, busy_b, load_b, ksl_b, 2'(key), dir_b, 2'(sh), ren_b, nsw_b, 4'(rnd),
            2'(pas), val_b};
  endfunction

  function automatic int key_of(input int np, input logic mode, input int p);
    if (np == 1) return 0;
    return mode ? 2 - p : p;
  endfunction

  // Expected per-cycle outputs from acceptance+1 up to and including DONE.
  task automatic build_trace(input int np, input int lat, input logic mode);
    exp_q.delete();
    msk_q.delete();
    exp_q.push_back(rec(1, 1, 1, key_of(np, mode, 0), 0, 0, 0, 0, 0, 0, 0));
    msk_q.push_back(ALL & ~(M_DIR | M_SH));
    for (int p = 0; p < np; p++) begin
      logic dir_b;
      dir_b = mode ^ (p == 1);
      for (int r = 0; r < 16; r++) begin
        for (int c = 0; c <= lat; c++) begin
          logic ren;
          ren = (c == lat);
          exp_q.push_back(rec(1, 0, 0, key_of(np, mode, p), dir_b,
                              dir_b ? dec_tab[r] : enc_tab[r], ren, ren && (r == 15),
                              r, p, 0));
          msk_q.push_back(ALL);
        end
      end
      if (p < np - 1) begin
        exp_q.push_back(rec(1, 0, 1, key_of(np, mode, p + 1), 0, 0, 0, 0, 0, 0, 0));
        msk_q.push_back(ALL & ~(M_DIR | M_SH | M_PASS));
      end
    end
    exp_q.push_back(DONE_REC);
    msk_q.push_back(DONE_MSK);
  endtask

  // Starts a block on DUT d at a negedge and follows it to the return to IDLE.
  task automatic run_txn(input int d, input logic mode, input int delay, input logic noisy,
                         input int exp_lat);
    int np, lat, per, first;
    np  = (d == 0) ? 3 : 1;
    lat = (d == 0) ? 0 : 1;
    per = 16 * (1 + lat) + 1;
    build_trace(np, lat, mode);
    for (int p = 0; p < 3; p++) begin
      obs_key[p] = 2'bxx;
      obs_dir[p] = 1'bx;
    end
    check("idle_before_start", obs[d], IDLE_REC, ALL);
    start_s[d] = 1'b1;
    mode_s[d]  = mode;
    @(negedge clk);
    start_s[d] = noisy ? 1'($urandom) : 1'b0;
    first = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("trace_d%0d_m%0d[%0d]", d, mode, i), obs[d], exp_q[i], msk_q[i]);
      if (obs[d][0] === 1'b1 && first < 0) first = i;
      if (i >= 1 && (i - 1) % per == 0 && (i - 1) / per < np) begin
        obs_key[(i - 1) / per] = obs[d][13:12];
        obs_dir[(i - 1) / per] = obs[d][11];
      end
      if (i == exp_q.size() - 1) break;
      if (noisy) begin
        start_s[d] = 1'($urandom);
        mode_s[d]  = 1'($urandom);
        ordy_s[d]  = 1'($urandom);
      end
      @(negedge clk);
    end
    check_int("latency", first, exp_lat);
    for (int k = 0; k < delay; k++) begin
      ordy_s[d]  = 1'b0;
      start_s[d] = 1'b1;
      @(negedge clk);
      check("done_held", obs[d], DONE_REC, DONE_MSK);
    end
    ordy_s[d]  = 1'b1;
    start_s[d] = 1'b1;
    @(negedge clk);
    check("idle_after_handshake", obs[d], IDLE_REC, ALL);
    ordy_s[d]  = 1'b0;
    start_s[d] = 1'b0;
    mode_s[d]  = 1'b0;
  endtask

  initial begin
    vecs[0] = '{0, 1'b0, 0,  1'b0, 51, 2'd0, 2'd1, 2'd2, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{0, 1'b1, 0,  1'b0, 51, 2'd2, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{0, 1'b0, 10, 1'b0, 51, 2'd0, 2'd1, 2'd2, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1, 1'b0, 0,  1'b0, 33, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1, 1'b1, 3,  1'b0, 33, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0};
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0;
      mode_s[d]  = 1'b0;
      ordy_s[d]  = 1'b0;
      abort_s[d] = 1'b0;
    end

    // Reset, then reset again while idle; nothing moves without start_i.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("reset_idle_d0", obs[0], IDLE_REC, ALL);
    check("reset_idle_d1", obs[1], IDLE_REC, ALL);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("quiet_idle_d0", obs[0], IDLE_REC, ALL);
    check("quiet_idle_d1", obs[1], IDLE_REC, ALL);

    // Table-driven blocks with per-pass key/direction expectations.
    for (int v = 0; v < 5; v++) begin
      run_txn(vecs[v].d, vecs[v].mode, vecs[v].delay, vecs[v].noisy, vecs[v].lat);
      check($sformatf("v%0d_key_pass0", v), 18'(obs_key[0]), 18'(vecs[v].k0), ALL);
      check($sformatf("v%0d_dir_pass0", v), 18'(obs_dir[0]), 18'(vecs[v].dr0), ALL);
      if (vecs[v].d == 0) begin
        check($sformatf("v%0d_key_pass1", v), 18'(obs_key[1]), 18'(vecs[v].k1), ALL);
        check($sformatf("v%0d_dir_pass1", v), 18'(obs_dir[1]), 18'(vecs[v].dr1), ALL);
        check($sformatf("v%0d_key_pass2", v), 18'(obs_key[2]), 18'(vecs[v].k2), ALL);
        check($sformatf("v%0d_dir_pass2", v), 18'(obs_dir[2]), 18'(vecs[v].dr2), ALL);
      end
    end

    // Asynchronous reset at pass 1 round 7, then a clean block.
    build_trace(3, 0, 1'b0);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    for (int i = 0; i <= 25; i++) begin
      check($sformatf("pre_reset[%0d]", i), obs[0], exp_q[i], msk_q[i]);
      if (i < 25) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_mid_op", obs[0], IDLE_REC, ALL);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(0, 1'b0, 1, 1'b0, 51);

    // Random blocks with stray start/mode/out_ready activity while busy.
    for (int n = 0; n < 6; n++) begin
      int d;
      d = int'($urandom_range(0, 1));
      run_txn(d, 1'($urandom), int'($urandom_range(0, 4)), 1'b1, (d == 0) ? 51 : 33);
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end

`ifdef TDES_CTRL_ABORT_EN
    // Abort during round 4 of the single-DES instance.
    begin
      logic seen_valid;
      build_trace(1, 1, 1'b0);
      start_s[1] = 1'b1;
      @(negedge clk);
      start_s[1] = 1'b0;
      for (int i = 0; i <= 9; i++) begin
        check($sformatf("pre_abort[%0d]", i), obs[1], exp_q[i], msk_q[i]);
        if (i < 9) @(negedge clk);
      end
      abort_s[1] = 1'b1;
      ordy_s[1]  = 1'b1;
      @(negedge clk);
      abort_s[1] = 1'b0;
      ordy_s[1]  = 1'b0;
      check("abort_to_idle", obs[1], IDLE_REC, ALL);
      seen_valid = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (out_valid[1] !== 1'b0) seen_valid = 1'b1;
      end
      check("abort_no_valid", 18'(seen_valid), 18'd0, ALL);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
